// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the synchronous FIFO read-side burst controller.
// Contents: FSM state encoding, default geometry constants, burst length type.
package syn_fifo_pkg;

  localparam int DEF_FIFO_ENTRIES = 16;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_LEN_WIDTH    = $clog2(DEF_FIFO_ENTRIES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [DEF_LEN_WIDTH-1:0] len_t;

endpackage

// File: rtl/syn_fifo_skid.sv
// Two-entry skid buffer sitting between the FIFO read data and the output
// stream. Absorbs the FIFO's one-cycle read latency so a stalled consumer
// never loses a word that was already requested.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push_i/push_data_i  write a word at the tail
//   pop_i               drop the head word (caller guarantees occ_o != 0)
//   occ_o               number of stored words, 0..2
//   data_o              head word, held stable until popped
module syn_fifo_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
  logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      if (wr_ptr_q) mem1_d = push_data_i;
      else          mem0_d = push_data_i;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_i) rd_ptr_d = ~rd_ptr_q;
    // push and pop together leave the occupancy unchanged
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign data_o = rd_ptr_q ? mem1_q : mem0_q;

endmodule

// File: rtl/syn_fifo_reader.sv
// Read-side burst controller: drains len_i words from the FIFO read port and
// presents them on a valid/ready stream through a 2-entry skid buffer.
// Optional feature macro: SYN_FIFO_READER_LAST_EN adds the m_last_o port.
//
// state | meaning
// IDLE  | waiting for start_i, len_i sampled on accept
// RUN   | issuing FIFO reads and delivering words
// DONE  | one-cycle completion pulse, then back to IDLE
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_i, len_i           burst command (sampled only in IDLE)
//   busy_o, done_o, count_o  status: not idle, end pulse, words delivered
//   fifo_rd_o, fifo_empty_i, fifo_data_i  FIFO read port (1-cycle latency)
//   m_valid_o, m_ready_i, m_data_o        output stream
//   m_last_o                 last word flag (SYN_FIFO_READER_LAST_EN only)
module syn_fifo_reader
  import syn_fifo_pkg::*;
#(
  parameter int FIFO_ENTRIES = DEF_FIFO_ENTRIES,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH    = $clog2(FIFO_ENTRIES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  count_o,
  output logic                  fifo_rd_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o
`ifdef SYN_FIFO_READER_LAST_EN
  ,
  output logic                  m_last_o
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] delivered_q, delivered_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           occ;
  logic                 pop;
  logic                 rd;
  logic                 room;

  assign m_valid_o = (occ != 2'd0);
  assign pop       = m_valid_o & m_ready_i;
  // words held or on their way, after this cycle's pop, must leave a free slot
  assign room = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    rd          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d       = len_i;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd = !fifo_empty_i && (issued_q < len_q) && room;
        if (rd)  issued_d    = issued_q + LEN_ONE;
        if (pop) delivered_d = delivered_q + LEN_ONE;
        if (pop && ((delivered_q + LEN_ONE) == len_q)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
    end
  end

  // read data arrives one cycle after the request; capture it then
  syn_fifo_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .data_o      (m_data_o)
  );

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign count_o   = delivered_q;
  assign fifo_rd_o = rd;

`ifdef SYN_FIFO_READER_LAST_EN
  assign m_last_o = m_valid_o & (delivered_q == (len_q - LEN_ONE));
`endif

endmodule
